dmem_stage: RTL
===============

// Module: dmem_stage
// PURPOSE
//   Memory-stage data memory unit of the 5-stage MIPS pipeline. Consumes aluoutM/writedataM from the
//   datapath and serves LW/SW from an internal word RAM with a programmable access latency. It returns
//   readdata to the M->W register and raises mem_stall to freeze the pipeline while an access is pending.
//   A combinational debug read port mirrors the register-file SW/rfsw style for board inspection.
// PARAMETERS
//   ADDR_W   6   word-address bits; RAM depth = 2**ADDR_W 32-bit words
//   LAT      2   access latency in cycles, legal range 1..15; equals the number of stall cycles per access
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   memreadM     in   1       load in M stage (memtoregM of the controller)
//   memwriteM    in   1       store in M stage
//   aluoutM      in   32      byte address; bits [ADDR_W+1:2] index the RAM
//   writedataM   in   32      store data
//   readdata     out  32      load result, registered; valid in the DONE cycle
//   mem_stall    out  1       1 = hold F/D/E/M; the hazard unit ORs this into stallF/stallD/stallE/stallM
//   misalign_err out  1       sticky; set when an access has aluoutM[1:0] != 0
//   dbg_addr     in   ADDR_W  debug word index
//   dbg_data     out  32      combinational RAM[dbg_addr]
// BEHAVIOUR
//   Reset: FSM goes to IDLE, cnt=0, readdata=0, mem_stall=0, misalign_err=0. RAM contents are not cleared.
//     Reset asserted mid-access aborts the access; a pending store is not committed.
//   FSM states IDLE, BUSY, DONE. req = memreadM | memwriteM.
//     IDLE: if req, mem_stall=1 in the same cycle (combinational), latch addr/data/op and cnt=LAT-1.
//       Next state is DONE if LAT==1, else BUSY. If no req, stay in IDLE with mem_stall=0.
//     BUSY: mem_stall=1. cnt decrements each cycle; when cnt==1, next state is DONE.
//     DONE: mem_stall=0, so the pipeline advances this edge. readdata holds RAM[addr] from the latched
//       address. A store commits to RAM at the edge that leaves DONE. Next state is IDLE unconditionally.
//       The instruction that follows enters M on this edge and is seen by IDLE one cycle later.
//   Timing: a request first seen in cycle t gives mem_stall high for cycles t..t+LAT-1.
//     DONE is cycle t+LAT. The W-stage register captures readdata at the end of cycle t+LAT.
//   Inputs are sampled only in IDLE. Changes on memreadM/aluoutM during BUSY/DONE are ignored.
//   readdata is updated only when a load reaches DONE. It holds its previous value on a store or when idle.
//   If memreadM and memwriteM are both 1, the access is a store and readdata returns the pre-write word
//     (read-before-write).
//   Address: aluoutM[1:0] are ignored for indexing. Upper bits above ADDR_W+1 are ignored, so the index
//     wraps modulo the RAM depth. A nonzero aluoutM[1:0] on any accepted request sets misalign_err;
//     the access still completes. Only rst clears misalign_err.
//   dbg_data: pure combinational read with no side effects. In the same cycle as a store commit it
//     shows the old word; from the next cycle it shows the new word.
// TESTING
//   1. LAT=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> mem_stall 2 cycles each; readdata=0xDEADBEEF in the
//      DONE cycle; dbg_addr=4 gives 0xDEADBEEF.
//   2. LAT=1: LW in IDLE -> mem_stall high exactly 1 cycle; a back-to-back LW/LW gives stall pulses
//      separated by 1 low cycle.
//   3. LW to address 0x13 -> misalign_err=1 and stays 1 after later aligned accesses; data equals word 4.
//   4. ADDR_W=6, SW to 0x100 -> wraps to word 0; dbg_addr=0 shows the stored value.
//   5. rst pulsed during BUSY of a SW 0x55 to 0x8 -> mem_stall=0, FSM in IDLE, RAM[2] unchanged, readdata=0.
//   6. memreadM=memwriteM=1, addr 0x0 holding 0x1, data 0x2 -> readdata=0x1; RAM[0]=0x2 afterwards.

Source files
------------

// File: rtl/dmem_stage.sv
// Memory-stage data memory for the 5-stage MIPS pipeline.
// Serves LW/SW from an internal word RAM with a fixed access latency of LAT
// cycles, freezes the pipeline through mem_stall while an access is pending,
// and exposes a side-effect-free combinational debug read port.
module dmem_stage #(
    parameter int ADDR_W = 6,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdata,
    output logic              mem_stall,
    output logic              misalign_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                rd_q;
    logic                wr_q;
    logic [31:0]         readdata_q;
    logic                misalign_q;
    logic [31:0]         mem_q [DEPTH];

    logic                req;
    logic [ADDR_W-1:0]   reqIdx_d;
    logic                unused_addrBits;

    // A request is any load or store; the word index drops the byte offset
    // and everything above the RAM depth so the address wraps.
    assign req             = memreadM | memwriteM;
    assign reqIdx_d        = aluoutM[ADDR_W+1:2];
    assign unused_addrBits = &{1'b0, aluoutM[31:ADDR_W+2]};

    // The stall must rise in the very cycle a request appears in IDLE, so it
    // is decoded combinationally from the current state and the request.
    assign mem_stall = ((state_q == IDLE) && req) || (state_q == BUSY);

    assign readdata     = readdata_q;
    assign misalign_err = misalign_q;
    assign dbg_data     = mem_q[dbg_addr];

    // Access sequencer: latches the request in IDLE, counts down the latency
    // in BUSY, and loads readdata on the edge entering DONE so it is valid
    // during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            readdata_q <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q <= reqIdx_d;
                        data_q <= writedataM;
                        rd_q   <= memreadM;
                        wr_q   <= memwriteM;
                        cnt_q  <= 4'(LAT - 1);
                        if (aluoutM[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                        if (LAT == 1) begin
                            state_q <= DONE;
                            if (memreadM) begin
                                readdata_q <= mem_q[reqIdx_d];
                            end
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                        if (rd_q) begin
                            readdata_q <= mem_q[addr_q];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stores commit on the edge that leaves DONE; the read in a combined
    // load/store already happened on the way in, giving read-before-write.
    always_ff @(posedge clk) begin
        if ((state_q == DONE) && wr_q) begin
            mem_q[addr_q] <= data_q;
        end
    end

endmodule
